// File: rtl/hbridge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hbridge_pkg : shared types, constants and helpers for the        |
// |               H-bridge PWM driver                                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hbridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [3:0] DIR_STOP = 4'b0000;

    localparam int DEF_PWM_BITS    = 8;
    localparam int DEF_DEAD_CYCLES = 1000;
    localparam int DEF_RAMP_DIV    = 4096;
    localparam int DEF_RAMP_STEP   = 4;

    // Both inputs of one half-bridge pair high would short the supply; treat as off.
    function automatic logic [3:0] sanitise_dir(input logic [3:0] dir);
        logic [1:0] side_a;
        logic [1:0] side_b;
        side_a = (dir[3:2] == 2'b11) ? 2'b00 : dir[3:2];
        side_b = (dir[1:0] == 2'b11) ? 2'b00 : dir[1:0];
        return {side_a, side_b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hbridge_pwm_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hbridge_pwm_gen : free-running PWM counter with period-aligned   |
// |                   duty shadow register and wrap pulse            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hbridge_pwm_gen
    import hbridge_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm,
    output logic                wrap
);

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] cnt_d;
    logic [PWM_BITS-1:0] shadow_q;
    logic [PWM_BITS-1:0] shadow_d;

    // Duty only changes at the period boundary so a pulse is never truncated or stretched.
    always_comb begin
        cnt_d    = cnt_q + PWM_BITS'(1);
        wrap     = (cnt_q == {PWM_BITS{1'b1}});
        shadow_d = wrap ? duty_in : shadow_q;
        pwm      = (cnt_q < shadow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hbridge_pwm_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hbridge_pwm_driver : L298N-style dual H-bridge driver with dead  |
// |   time, shoot-through blocking and PWM enables.                  |
// |   Optional soft start: define HBRIDGE_SOFT_START_EN.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hbridge_pwm_driver
    import hbridge_pkg::*;
#(
    parameter int PWM_BITS    = DEF_PWM_BITS,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int RAMP_DIV    = DEF_RAMP_DIV,
    parameter int RAMP_STEP   = DEF_RAMP_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          dir_in,
    input  logic [PWM_BITS-1:0] duty_cmd,
    output logic [3:0]          hb_in,
    output logic                hb_en_a,
    output logic                hb_en_b,
    output logic                busy
);

    localparam int                DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          dir_q, dir_d;
    logic [3:0]          applied_q, applied_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic [PWM_BITS-1:0] duty_eff_q, duty_eff_d;
    logic                en_a_q, en_a_d;
    logic                en_b_q, en_b_d;
    logic                busy_q, busy_d;
    logic                ramping;
    logic                pwm;
    logic                wrap_unused;

    assign dir_d = sanitise_dir(dir_in);

    // applied is held at DIR_STOP in IDLE and DEAD, so it is the bridge pin value directly.
    always_comb begin
        state_d    = state_q;
        applied_d  = applied_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            ST_IDLE: begin
                applied_d = DIR_STOP;
                if (dir_q != DIR_STOP) begin
                    state_d   = ST_RUN;
                    applied_d = dir_q;
                end
            end
            ST_RUN: begin
                if (dir_q == DIR_STOP) begin
                    state_d   = ST_IDLE;
                    applied_d = DIR_STOP;
                end else if (dir_q != applied_q) begin
                    state_d    = ST_DEAD;
                    applied_d  = DIR_STOP;
                    dead_cnt_d = '0;
                end
            end
            ST_DEAD: begin
                applied_d = DIR_STOP;
                if (dead_cnt_q == DEAD_LAST) begin
                    dead_cnt_d = '0;
                    if (dir_q != DIR_STOP) begin
                        state_d   = ST_RUN;
                        applied_d = dir_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                applied_d = DIR_STOP;
            end
        endcase
    end

`ifdef HBRIDGE_SOFT_START_EN
    localparam int                RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [RAMP_W-1:0]   ramp_tmr_q, ramp_tmr_d;
    logic                ramp_tick;
    logic [PWM_BITS:0]   ramp_sum;

    // Any cycle outside RUN (including the entry cycle) restarts the ramp from zero.
    always_comb begin
        ramp_tmr_d = ramp_tmr_q;
        ramp_tick  = 1'b0;
        duty_eff_d = duty_eff_q;
        ramp_sum   = {1'b0, duty_eff_q} + (PWM_BITS + 1)'(RAMP_STEP);
        if (state_q != ST_RUN) begin
            ramp_tmr_d = '0;
            duty_eff_d = '0;
        end else begin
            ramp_tick  = (ramp_tmr_q == RAMP_LAST);
            ramp_tmr_d = ramp_tick ? '0 : ramp_tmr_q + RAMP_W'(1);
            if (duty_cmd < duty_eff_q) begin
                duty_eff_d = duty_cmd;
            end else if (ramp_tick) begin
                duty_eff_d = (ramp_sum > {1'b0, duty_cmd}) ? duty_cmd : ramp_sum[PWM_BITS-1:0];
            end
        end
        ramping = (state_d == ST_RUN) && (duty_eff_d != duty_cmd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_tmr_q <= '0;
        end else begin
            ramp_tmr_q <= ramp_tmr_d;
        end
    end
`else
    logic [1:0] ramp_cfg_unused;
    assign ramp_cfg_unused = {RAMP_DIV[0], RAMP_STEP[0]};

    always_comb begin
        duty_eff_d = duty_cmd;
        ramping    = 1'b0;
    end
`endif

    hbridge_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty_in (duty_eff_q),
        .pwm     (pwm),
        .wrap    (wrap_unused)
    );

    always_comb begin
        en_a_d = pwm & (|applied_d[3:2]);
        en_b_d = pwm & (|applied_d[1:0]);
        busy_d = (state_d == ST_DEAD) | ramping;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_STOP;
            applied_q  <= DIR_STOP;
            dead_cnt_q <= '0;
            duty_eff_q <= '0;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            applied_q  <= applied_d;
            dead_cnt_q <= dead_cnt_d;
            duty_eff_q <= duty_eff_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            busy_q     <= busy_d;
        end
    end

    assign hb_in   = applied_q;
    assign hb_en_a = en_a_q;
    assign hb_en_b = en_b_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_pwm_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hbridge_pwm_driver : directed self-checking bench for the     |
// |   H-bridge driver; expectations follow HBRIDGE_SOFT_START_EN     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_hbridge_pwm_driver;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] dir_in   = 4'b0000;
    logic [7:0] duty_cmd = 8'd0;
    logic [3:0] hb_in;
    logic       hb_en_a;
    logic       hb_en_b;
    logic       busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hbridge_pwm_driver #(
        .PWM_BITS    (8),
        .DEAD_CYCLES (16),
        .RAMP_DIV    (8),
        .RAMP_STEP   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dir_in   (dir_in),
        .duty_cmd (duty_cmd),
        .hb_in    (hb_in),
        .hb_en_a  (hb_en_a),
        .hb_en_b  (hb_en_b),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_en(input int n, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (hb_en_a) ca++;
            if (hb_en_b) cb++;
        end
    endtask

    // Returns once hb_en_b has just risen, i.e. at the start of a PWM period.
    task automatic sync_rise_b(output bit found);
        logic prev;
        int   n;
        found = 1'b0;
        n     = 0;
        prev  = hb_en_b;
        while (!found && n < 600) begin
            tick();
            n++;
            if (!prev && hb_en_b) found = 1'b1;
            prev = hb_en_b;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dir_in = 4'b0000; duty_cmd = 8'd0;
        tick_n(3);
        checks++; if (hb_in !== 4'b0000) $display("FAIL reset_hb_in: got %b expected 0000", hb_in); else passes++;
        checks++; if (hb_en_a !== 1'b0) $display("FAIL reset_en_a: got %b expected 0", hb_en_a); else passes++;
        checks++; if (hb_en_b !== 1'b0) $display("FAIL reset_en_b: got %b expected 0", hb_en_b); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        rst_n = 1'b1;
        tick_n(2);
    endtask

    task automatic test_run_ramp();
        int n, ca, cb;
        duty_cmd = 8'd128; dir_in = 4'b1001;
        tick();
        checks++; if (hb_in !== 4'b0000) $display("FAIL run_latency: got %b expected 0000", hb_in); else passes++;
        tick();
        checks++; if (hb_in !== 4'b1001) $display("FAIL run_hb_in: got %b expected 1001", hb_in); else passes++;
`ifdef HBRIDGE_SOFT_START_EN
        checks++; if (busy !== 1'b1) $display("FAIL run_busy_ramp: got %b expected 1", busy); else passes++;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin tick(); n++; end
        checks++; if (n != 256) $display("FAIL ramp_cycles: got %0d expected 256", n); else passes++;
`else
        checks++; if (busy !== 1'b0) $display("FAIL run_busy_nosoft: got %b expected 0", busy); else passes++;
`endif
        tick_n(300);
        count_en(256, ca, cb);
        checks++; if (ca != 128) $display("FAIL run_duty_a: got %0d expected 128", ca); else passes++;
        checks++; if (cb != 128) $display("FAIL run_duty_b: got %0d expected 128", cb); else passes++;
    endtask

    task automatic test_reversal();
        int n;
        bit bad_en, busy_lo;
        dir_in = 4'b0110;
        tick();
        checks++; if (hb_in !== 4'b1001) $display("FAIL rev_hold: got %b expected 1001", hb_in); else passes++;
        tick();
        checks++; if (hb_in !== 4'b0000) $display("FAIL rev_break: got %b expected 0000", hb_in); else passes++;
        n = 0; bad_en = 1'b0; busy_lo = 1'b0;
        while (hb_in === 4'b0000 && n < 100) begin
            if (hb_en_a || hb_en_b) bad_en = 1'b1;
            if (busy !== 1'b1) busy_lo = 1'b1;
            tick();
            n++;
        end
        checks++; if (n != 16) $display("FAIL rev_dead_len: got %0d expected 16", n); else passes++;
        checks++; if (bad_en) $display("FAIL rev_dead_en: got 1 expected 0"); else passes++;
        checks++; if (busy_lo) $display("FAIL rev_dead_busy: got 0 expected 1"); else passes++;
        checks++; if (hb_in !== 4'b0110) $display("FAIL rev_new_dir: got %b expected 0110", hb_in); else passes++;
`ifdef HBRIDGE_SOFT_START_EN
        checks++; if (busy !== 1'b1) $display("FAIL rev_ramp_restart: got %b expected 1", busy); else passes++;
`else
        checks++; if (busy !== 1'b0) $display("FAIL rev_busy_after: got %b expected 0", busy); else passes++;
`endif
    endtask

    task automatic test_dead_change();
        int n;
        tick_n(20);
        dir_in = 4'b1001;
        tick_n(2);
        checks++; if (hb_in !== 4'b0000) $display("FAIL dc_break: got %b expected 0000", hb_in); else passes++;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 3) dir_in = 4'b1000;
            if (n == 6) dir_in = 4'b0000;
            tick();
            n++;
        end
        checks++; if (n != 16) $display("FAIL dc_dead_len: got %0d expected 16", n); else passes++;
        checks++; if (hb_in !== 4'b0000) $display("FAIL dc_idle_hb: got %b expected 0000", hb_in); else passes++;
        tick_n(10);
        checks++; if (hb_in !== 4'b0000) $display("FAIL dc_idle_stay: got %b expected 0000", hb_in); else passes++;
        checks++; if (hb_en_a !== 1'b0 || hb_en_b !== 1'b0) $display("FAIL dc_idle_en: got %b%b expected 00", hb_en_a, hb_en_b); else passes++;
    endtask

    task automatic test_illegal();
        int ca, cb;
        dir_in = 4'b1100;
        tick_n(3);
        checks++; if (hb_in !== 4'b0000) $display("FAIL ill_a_hb: got %b expected 0000", hb_in); else passes++;
        count_en(300, ca, cb);
        checks++; if (ca != 0) $display("FAIL ill_a_en_a: got %0d expected 0", ca); else passes++;
        checks++; if (cb != 0) $display("FAIL ill_a_en_b: got %0d expected 0", cb); else passes++;
        dir_in = 4'b1101;
        tick_n(2);
        checks++; if (hb_in !== 4'b0001) $display("FAIL ill_b_hb: got %b expected 0001", hb_in); else passes++;
        tick_n(600);
        count_en(256, ca, cb);
        checks++; if (ca != 0) $display("FAIL ill_b_en_a: got %0d expected 0", ca); else passes++;
        checks++; if (cb != 128) $display("FAIL ill_b_en_b: got %0d expected 128", cb); else passes++;
    endtask

    task automatic test_duty_step();
        int ca, cb;
        bit found;
        duty_cmd = 8'd200;
        tick_n(500);
        sync_rise_b(found);
        checks++; if (!found) $display("FAIL step_sync1: got timeout expected rise"); else passes++;
        tick_n(100);
        duty_cmd = 8'd50;
        tick_n(2);
        checks++; if (busy !== 1'b0) $display("FAIL step_busy: got %b expected 0", busy); else passes++;
        sync_rise_b(found);
        checks++; if (!found) $display("FAIL step_sync2: got timeout expected rise"); else passes++;
        count_en(256, ca, cb);
        checks++; if (cb != 50) $display("FAIL step_duty50: got %0d expected 50", cb); else passes++;
        duty_cmd = 8'd0;
        tick_n(300);
        count_en(300, ca, cb);
        checks++; if (cb != 0) $display("FAIL zero_duty: got %0d expected 0", cb); else passes++;
    endtask

    task automatic test_async_reset();
        int ca, cb;
        bit found;
        duty_cmd = 8'd128;
        tick_n(600);
        sync_rise_b(found);
        tick_n(10);
        checks++; if (hb_en_b !== 1'b1) $display("FAIL ar_pre_en_b: got %b expected 1", hb_en_b); else passes++;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (hb_in !== 4'b0000) $display("FAIL ar_async_hb: got %b expected 0000", hb_in); else passes++;
        checks++; if (hb_en_a !== 1'b0 || hb_en_b !== 1'b0) $display("FAIL ar_async_en: got %b%b expected 00", hb_en_a, hb_en_b); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL ar_async_busy: got %b expected 0", busy); else passes++;
        tick_n(3);
        rst_n = 1'b1;
        tick();
        checks++; if (hb_in !== 4'b0000) $display("FAIL ar_latency: got %b expected 0000", hb_in); else passes++;
        tick();
        checks++; if (hb_in !== 4'b0001) $display("FAIL ar_restart: got %b expected 0001", hb_in); else passes++;
`ifdef HBRIDGE_SOFT_START_EN
        checks++; if (busy !== 1'b1) $display("FAIL ar_ramp_restart: got %b expected 1", busy); else passes++;
`endif
        count_en(250, ca, cb);
        checks++; if (cb != 0) $display("FAIL ar_first_period: got %0d expected 0", cb); else passes++;
`ifndef HBRIDGE_SOFT_START_EN
        tick_n(10);
        count_en(256, ca, cb);
        checks++; if (cb != 128) $display("FAIL ar_full_duty: got %0d expected 128", cb); else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_run_ramp();
        test_reversal();
        test_dead_change();
        test_illegal();
        test_duty_step();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
